// File: rtl/seq_ser_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
package seq_ser_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;

  // Length 0 or anything above the register width means a full-width frame.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/seq_ser_if.sv
// Load port and serial stream of the serializer.
interface seq_ser_if #(
  parameter int WIDTH = 16,
  parameter int LENW  = $clog2(WIDTH + 1)
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic [LENW-1:0]  load_len;
  logic             load_ready;
  logic             stall;
  logic             ser_bit;
  logic             ser_valid;
  logic             busy;
  logic [LENW-1:0]  bits_left;
  logic             frame_done;

  modport slave (
    input  load_valid, load_data, load_len, stall,
    output load_ready, ser_bit, ser_valid, busy, bits_left, frame_done
  );

  modport master (
    output load_valid, load_data, load_len, stall,
    input  load_ready, ser_bit, ser_valid, busy, bits_left, frame_done
  );
endinterface

// File: rtl/seq_ser_shreg.sv
// MSB-first shift register with its remaining-bit counter.
module seq_ser_shreg #(
  parameter int WIDTH = 16,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_sr,
  input  logic [LENW-1:0]  load_cnt,
  output logic             msb,
  output logic [LENW-1:0]  cnt
);
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LENW-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      sr_d  = load_sr;
      cnt_d = load_cnt;
    end else if (shift_en && cnt_q != '0) begin
      sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb = sr_q[WIDTH-1];
  assign cnt = cnt_q;
endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: loads a frame, streams it MSB-first with stall support.
module seq_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic      clk,
  input  logic      rst,
  seq_ser_if.slave  bus
);
  state_t           state_q, state_d;
  logic             frame_done_q, frame_done_d;
  logic             in_shift, last_bit, xfer, clear, shift_en, msb;
  logic [LENW-1:0]  cnt, load_cnt;
  logic [WIDTH-1:0] load_sr;
  int unsigned      eff;

  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = in_shift && cnt == LENW'(1) && !bus.stall;
  assign bus.load_ready = (state_q == ST_IDLE) || last_bit;
  assign xfer     = bus.load_valid && bus.load_ready;
  assign shift_en = in_shift && !bus.stall;

  // Left-justify the used field so the first bit sits in the MSB.
  assign eff      = eff_len(32'(bus.load_len), WIDTH);
  assign load_cnt = LENW'(eff);
  assign load_sr  = bus.load_data << (WIDTH - eff);

  always_comb begin
    state_d      = state_q;
    clear        = 1'b0;
    frame_done_d = last_bit;
    case (state_q)
      ST_IDLE:  if (xfer) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit && !xfer) state_d = ST_IDLE;
      default: begin
        state_d      = ST_IDLE;
        clear        = 1'b1;
        frame_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  seq_ser_shreg #(.WIDTH(WIDTH), .LENW(LENW)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (xfer),
    .shift_en (shift_en),
    .clear    (clear),
    .load_sr  (load_sr),
    .load_cnt (load_cnt),
    .msb      (msb),
    .cnt      (cnt)
  );

  assign bus.ser_bit    = msb;
  assign bus.ser_valid  = in_shift && !bus.stall;
  assign bus.busy       = in_shift;
  assign bus.bits_left  = in_shift ? cnt : '0;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seq_serializer.sv
// Directed, table-driven bench for seq_serializer (WIDTH=16).
module tb_seq_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_ser_if #(.WIDTH(16)) bus ();
  seq_serializer #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        lv;
    logic [15:0] ld;
    logic [4:0]  ll;
    logic        st;
    logic        e_bit, e_val, e_busy;
    logic [4:0]  e_left;
    logic        e_done, e_rdy;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic lv, input logic [15:0] ld, input logic [4:0] ll, input logic st,
                     input logic eb, input logic ev, input logic ebusy, input logic [4:0] eleft,
                     input logic edone, input logic erdy);
    vec_t v;
    v.lv = lv; v.ld = ld; v.ll = ll; v.st = st;
    v.e_bit = eb; v.e_val = ev; v.e_busy = ebusy; v.e_left = eleft;
    v.e_done = edone; v.e_rdy = erdy;
    tbl.push_back(v);
  endtask

  // n unstalled bits taken MSB-first from pat[n-1:0], counting down from left0.
  task automatic push_bits(input logic [15:0] pat, input int n, input int left0,
                           input logic lv, input logic [15:0] ld, input logic [4:0] ll);
    for (int i = 0; i < n; i++) begin
      logic [4:0] l;
      l = 5'(left0 - i);
      add(lv, ld, ll, 1'b0, pat[n-1-i], 1'b1, 1'b1, l, 1'b0, l == 5'd1);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus.load_valid = tbl[i].lv;
      bus.load_data  = tbl[i].ld;
      bus.load_len   = tbl[i].ll;
      bus.stall      = tbl[i].st;
      #1;
      chk($sformatf("%s[%0d].ser_bit", tag, i),    32'(bus.ser_bit),    32'(tbl[i].e_bit));
      chk($sformatf("%s[%0d].ser_valid", tag, i),  32'(bus.ser_valid),  32'(tbl[i].e_val));
      chk($sformatf("%s[%0d].busy", tag, i),       32'(bus.busy),       32'(tbl[i].e_busy));
      chk($sformatf("%s[%0d].bits_left", tag, i),  32'(bus.bits_left),  32'(tbl[i].e_left));
      chk($sformatf("%s[%0d].frame_done", tag, i), 32'(bus.frame_done), 32'(tbl[i].e_done));
      chk($sformatf("%s[%0d].load_ready", tag, i), 32'(bus.load_ready), 32'(tbl[i].e_rdy));
    end
    tbl.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ser_bit"},    32'(bus.ser_bit),    32'd0);
    chk({tag, ".ser_valid"},  32'(bus.ser_valid),  32'd0);
    chk({tag, ".busy"},       32'(bus.busy),       32'd0);
    chk({tag, ".bits_left"},  32'(bus.bits_left),  32'd0);
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, ".load_ready"}, 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_len   = '0;
    bus.stall      = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // full-width frame, len=0
    add(1, 16'hB058, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    push_bits(16'b1011_0000_0101_1000, 16, 16, 0, 16'h0, 5'd0);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    run_table("full");

    // short frame, len=5
    add(1, 16'h0016, 5'd5, 0, 0, 0, 0, 5'd0, 0, 1);
    push_bits(16'b10110, 5, 5, 0, 16'h0, 5'd0);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    run_table("short");

    // stall 3 cycles on bit 4
    add(1, 16'hB058, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    push_bits(16'b101, 3, 16, 0, 16'h0, 5'd0);
    for (int i = 0; i < 3; i++) add(0, 16'h0, 5'd0, 1, 1, 0, 1, 5'd13, 0, 0);
    push_bits(16'b1_0000_0101_1000, 13, 13, 0, 16'h0, 5'd0);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1);
    add(0, 16'h0, 5'd0, 1, 0, 0, 0, 5'd0, 0, 1);
    run_table("stall");

    // back-to-back frames 101 then 11, no bubble
    add(1, 16'h0005, 5'd3, 0, 0, 0, 0, 5'd0, 0, 1);
    add(1, 16'h0003, 5'd2, 0, 1, 1, 1, 5'd3, 0, 0);
    add(1, 16'h0003, 5'd2, 0, 0, 1, 1, 5'd2, 0, 0);
    add(1, 16'h0003, 5'd2, 0, 1, 1, 1, 5'd1, 0, 1);
    add(0, 16'h0, 5'd0, 0, 1, 1, 1, 5'd2, 1, 0);
    add(0, 16'h0, 5'd0, 0, 1, 1, 1, 5'd1, 0, 1);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    run_table("b2b");

    // len=20 clamps to 16; load while busy ignored
    add(1, 16'h8001, 5'd20, 0, 0, 0, 0, 5'd0, 0, 1);
    push_bits(16'b1000_0000, 8, 16, 1, 16'hFFFF, 5'd3);
    push_bits(16'b0000_0001, 8, 8, 0, 16'h0, 5'd0);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    run_table("clamp");

    // async reset mid-frame at bits_left=7
    add(1, 16'hB058, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    push_bits(16'b1_0110_0000, 9, 16, 0, 16'h0, 5'd0);
    run_table("pre_rst");
    @(posedge clk);
    #3;
    chk("mid.bits_left", 32'(bus.bits_left), 32'd7);
    chk("mid.ser_bit",   32'(bus.ser_bit),   32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    add(1, 16'h0016, 5'd5, 0, 0, 0, 0, 5'd0, 0, 1);
    push_bits(16'b10110, 5, 5, 0, 16'h0, 5'd0);
    add(0, 16'h0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1);
    run_table("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
